// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl - time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display, feeding a 5-bit-code -> segment decoder.
//
// Each digit slot is CLK_DIV cycles long. The first BLANK_CYCLES of a slot show
// nothing, which gives the anode drivers time to turn off. The rest of the slot
// lights the digit. The display word is double-buffered: a load only takes
// effect at a frame boundary, so the display never shows half old and half new
// digits. Leading zeros can be blanked.
//
// Ports
//   iCLK    system clock, rising edge
//   iRST_N  synchronous reset, active low
//   iDATA   packed digit codes, digit k = iDATA[5k+4:5k], digit 0 rightmost
//   iLOAD   1-cycle update request; iDATA/iLZB are sampled in the same cycle
//   iLZB    leading-zero blank enable, staged together with iDATA
//   oDIG    code to the decoder, 5'h1F = blank
//   oAN     one-hot-low digit enable, all ones = nothing lit
//   oBUSY   a staged update is waiting for the frame boundary
//   oFRAME  1-cycle pulse in the first cycle of every frame

// Per-digit leading-zero decision. A digit is blanked when it is a zero and
// everything above it is either zero or already blank. Digit 0 is always shown.
module seg7_lzb_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [4:0] i_code,
  input  logic       i_above_ok,
  input  logic       i_lzb_en,
  output logic       o_blank
);
  assign o_blank = i_lzb_en && !IS_LSD && (i_code == 5'h00) && i_above_ok;
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [5*NUM_DIGITS-1:0] iDATA,
  input  logic                    iLOAD,
  input  logic                    iLZB,
  output logic [4:0]              oDIG,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oBUSY,
  output logic                    oFRAME
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [31:0]   BLANK_U  = BLANK_CYCLES;

  logic [CW-1:0]                r_cnt;
  logic [IW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][4:0]   r_stg, r_disp;
  logic                         r_stg_lzb, r_lzb, r_pend;
  logic [4:0]                   r_dig;
  logic [NUM_DIGITS-1:0]        r_an;
  logic                         r_frame;

  logic                         w_cnt_wrap, w_bnd, w_on;
  logic [NUM_DIGITS-1:0]        w_above, w_blank;
  logic [4:0]                   w_dig_nxt;
  logic [NUM_DIGITS-1:0]        w_an_nxt;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_bnd      = w_cnt_wrap && (r_idx == IDX_LAST);
  assign w_on       = (32'(r_cnt) >= BLANK_U);

  // w_above[k]: every digit above k is 0 or blank, so digit k is a leading
  // position. Built from the most significant digit downwards.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    if (k == NUM_DIGITS - 1) begin : g_top
      assign w_above[k] = 1'b1;
    end else begin : g_chain
      assign w_above[k] = w_above[k+1] &&
                          ((r_disp[k+1] == 5'h00) || (r_disp[k+1] == 5'h1F));
    end
    seg7_lzb_lane #(.IS_LSD(k == 0)) u_lane (
      .i_code     (r_disp[k]),
      .i_above_ok (w_above[k]),
      .i_lzb_en   (r_lzb),
      .o_blank    (w_blank[k])
    );
  end

  always_comb begin
    w_dig_nxt = 5'h1F;
    w_an_nxt  = '1;
    if (w_on && !w_blank[r_idx]) begin
      w_dig_nxt = r_disp[r_idx];
      w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_stg     <= '1;
      r_disp    <= '1;
      r_stg_lzb <= 1'b0;
      r_lzb     <= 1'b0;
      r_pend    <= 1'b0;
      r_dig     <= 5'h1F;
      r_an      <= '1;
      r_frame   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + CW'(1);
      if (w_cnt_wrap)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      // The display takes the staging contents as they were before this edge,
      // so a load landing on the boundary itself waits one more frame.
      if (w_bnd && r_pend) begin
        r_disp <= r_stg;
        r_lzb  <= r_stg_lzb;
      end
      if (iLOAD) begin
        r_stg     <= iDATA;
        r_stg_lzb <= iLZB;
        r_pend    <= 1'b1;
      end else if (w_bnd) begin
        r_pend <= 1'b0;
      end
      r_frame <= w_bnd;
      r_dig   <= w_dig_nxt;
      r_an    <= w_an_nxt;
    end
  end

  assign oDIG   = r_dig;
  assign oAN    = r_an;
  assign oBUSY  = r_pend;
  assign oFRAME = r_frame;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
// A cycle-level reference model pushes the expected outputs on every rising
// edge. Each falling edge pops one entry and compares it, and directed
// constant checks cover the scan scenarios.
module tb_seg7_scan_ctrl;
  localparam int ND = 4, CD = 8, BC = 2, FRM = ND * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] data = '0;
  logic        load = 1'b0, lzb = 1'b0;
  logic [4:0]  dig;
  logic [3:0]  an;
  logic        busy, frame;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iLOAD(load), .iLZB(lzb),
    .oDIG(dig), .oAN(an), .oBUSY(busy), .oFRAME(frame)
  );

  typedef struct packed {
    logic [4:0] dig;
    logic [3:0] an;
    logic       busy;
    logic       frame;
  } out_t;

  out_t q[$];
  int   n_chk = 0, n_fail = 0;

  // Reference model. It tracks the position in the frame as one cycle count.
  int         m_t;
  logic [4:0] m_disp[ND], m_stg[ND];
  logic       m_lzb, m_slzb, m_pend;

  function automatic bit lz_blank(int k);
    if (!m_lzb || k == 0 || m_disp[k] != 5'h00) return 1'b0;
    for (int j = k + 1; j < ND; j++)
      if (m_disp[j] != 5'h00 && m_disp[j] != 5'h1F) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    out_t e;
    int   slot, ph;
    bit   bnd;
    if (!rst_n) begin
      e = '{dig: 5'h1F, an: 4'hF, busy: 1'b0, frame: 1'b0};
      m_t = 0; m_lzb = 1'b0; m_slzb = 1'b0; m_pend = 1'b0;
      for (int k = 0; k < ND; k++) begin m_disp[k] = 5'h1F; m_stg[k] = 5'h1F; end
    end else begin
      slot = m_t / CD;
      ph   = m_t % CD;
      bnd  = (m_t == FRM - 1);
      e.frame = bnd;
      e.dig   = 5'h1F;
      e.an    = 4'hF;
      if (ph >= BC && !lz_blank(slot)) begin
        e.dig      = m_disp[slot];
        e.an[slot] = 1'b0;
      end
      if (bnd && m_pend) begin
        for (int k = 0; k < ND; k++) m_disp[k] = m_stg[k];
        m_lzb = m_slzb;
      end
      if (load) begin
        for (int k = 0; k < ND; k++) m_stg[k] = data[5*k +: 5];
        m_slzb = lzb;
        m_pend = 1'b1;
      end else if (bnd) begin
        m_pend = 1'b0;
      end
      e.busy = m_pend;
      m_t = bnd ? 0 : m_t + 1;
    end
    q.push_back(e);
  end

  task automatic tick();
    out_t e, o;
    @(negedge clk);
    o = '{dig: dig, an: an, busy: busy, frame: frame};
    if (q.size() != 0) begin
      e = q.pop_front();
      n_chk++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL sb t=%0t observed=%h expected=%h", $time, o, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    tick();
    while (frame !== 1'b1 && n < 2 * FRM) begin tick(); n++; end
    chk("frame_seen", 32'(frame), 32'h1);
  endtask

  task automatic pulse_load(input logic [19:0] d, input logic z);
    data = d; lzb = z; load = 1'b1;
    tick();
    load = 1'b0; lzb = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, input logic [4:0] ed);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_dig"}, 32'(dig), 32'(ed));
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk_out("rst", 4'hF, 5'h1F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    rst_n = 1'b1;

    // 1: blank display scans. At the frame pulse the outputs still show slot 3 ON.
    wait_frame();
    chk_out("t1_f", 4'h7, 5'h1F);
    chk("t1_busy", 32'(busy), 32'h0);
    tick();          chk_out("t1_blank", 4'hF, 5'h1F);
    repeat (2) tick(); chk_out("t1_on0", 4'hE, 5'h1F);

    // 2: plain digits
    repeat (2) tick();
    pulse_load({5'h04, 5'h03, 5'h02, 5'h01}, 1'b0);
    chk("t2_busy", 32'(busy), 32'h1);
    wait_frame();
    chk("t2_busy_clr", 32'(busy), 32'h0);
    tick(); chk_out("t2_b0", 4'hF, 5'h1F);
    tick(); chk_out("t2_b1", 4'hF, 5'h1F);
    tick(); chk_out("t2_s0", 4'hE, 5'h01);
    repeat (8) tick(); chk_out("t2_s1", 4'hD, 5'h02);
    repeat (8) tick(); chk_out("t2_s2", 4'hB, 5'h03);
    repeat (8) tick(); chk_out("t2_s3", 4'h7, 5'h04);

    // 3: leading-zero blank with an embedded zero
    pulse_load({5'h00, 5'h00, 5'h07, 5'h00}, 1'b1);
    wait_frame();
    repeat (3) tick(); chk_out("t3_s0", 4'hE, 5'h00);
    repeat (8) tick(); chk_out("t3_s1", 4'hD, 5'h07);
    repeat (8) tick(); chk_out("t3_s2", 4'hF, 5'h1F);
    repeat (8) tick(); chk_out("t3_s3", 4'hF, 5'h1F);

    // 4: all zeros, blanked and then unblanked
    pulse_load(20'h0, 1'b1);
    wait_frame();
    repeat (3) tick(); chk_out("t4_s0", 4'hE, 5'h00);
    repeat (8) tick(); chk_out("t4_s1", 4'hF, 5'h1F);
    pulse_load(20'h0, 1'b0);
    wait_frame();
    repeat (11) tick(); chk_out("t4_nz1", 4'hD, 5'h00);
    repeat (16) tick(); chk_out("t4_nz3", 4'h7, 5'h00);

    // 5: latest load wins, and a load on the boundary cycle waits a frame
    wait_frame();
    repeat (5) tick();
    pulse_load({5'h01, 5'h02, 5'h03, 5'h0A}, 1'b0);
    repeat (14) tick();
    pulse_load({5'h04, 5'h05, 5'h06, 5'h0B}, 1'b0);
    repeat (10) tick();
    pulse_load({5'h07, 5'h08, 5'h09, 5'h0C}, 1'b0);
    chk("t5_frame", 32'(frame), 32'h1);
    chk("t5_busy", 32'(busy), 32'h1);
    repeat (3) tick();  chk_out("t5_B", 4'hE, 5'h0B);
    repeat (13) tick(); chk("t5_busy_mid", 32'(busy), 32'h1);
    repeat (16) tick();
    chk("t5_frame2", 32'(frame), 32'h1);
    chk("t5_busy_clr", 32'(busy), 32'h0);
    repeat (3) tick();  chk_out("t5_C", 4'hE, 5'h0C);

    // 6: mid-frame reset drops a pending load
    pulse_load({5'h11, 5'h12, 5'h13, 5'h14}, 1'b0);
    chk("t6_busy", 32'(busy), 32'h1);
    repeat (13) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t6_rst", 4'hF, 5'h1F);
    chk("t6_busy0", 32'(busy), 32'h0);
    chk("t6_frame0", 32'(frame), 32'h0);
    repeat (3) tick(); chk_out("t6_s0", 4'hE, 5'h1F);
    wait_frame();
    chk("t6_busy_f", 32'(busy), 32'h0);
    repeat (11) tick(); chk_out("t6_s1", 4'hD, 5'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
